// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks: segment
// bit positions, digit patterns and the scan controller state encoding.
package seg_pkg;

    // Bit positions inside the 8-bit segment bus {dp,g,f,e,d,c,b,a}
    localparam int SEG_BIT_A  = 0;
    localparam int SEG_BIT_B  = 1;
    localparam int SEG_BIT_C  = 2;
    localparam int SEG_BIT_D  = 3;
    localparam int SEG_BIT_E  = 4;
    localparam int SEG_BIT_F  = 5;
    localparam int SEG_BIT_G  = 6;
    localparam int SEG_BIT_DP = 7;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Scan controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD to seven-segment decoder. Nibbles outside 0..9 are
// shown as a centre dash so corrupted data is visible rather than hidden.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    // Map one BCD nibble onto its segment pattern
    always_comb begin
        pattern = SEG_OFF;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller. Drives one segment bus
// across DIGITS common-select lines with a blanking gap before every
// digit. New frames arrive over valid/ready into a pending buffer and are
// only moved to the displayed (shadow) frame at a frame boundary, so a
// frame is never shown half old and half new.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS     = 2,
    parameter int DIV_CNT    = 50000,
    parameter int BLANK_CYC  = 500,
    parameter int LEAD_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  en,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [4*DIGITS-1:0]   upd_bcd,
    input  logic [DIGITS-1:0]     upd_dp,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int T_MAX = (DIV_CNT > BLANK_CYC) ? DIV_CNT : BLANK_CYC;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
    localparam logic [TW-1:0] SHOW_LAST  = TW'(DIV_CNT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    scan_state_e            state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [4*DIGITS-1:0]    shadow_bcd_q, shadow_bcd_d;
    logic [DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0]    pend_bcd_q, pend_bcd_d;
    logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
    logic                   pend_v_q, pend_v_d;
    logic                   upd_ready_q, upd_ready_d;
    logic [DIGITS-1:0]      digit_sel_q, digit_sel_d;
    logic [7:0]             seg_q, seg_d;
    logic                   frame_start_q, frame_start_d;

    logic                   xfer_s;
    logic                   boundary_s;
    logic [DIGITS-1:0]      lead_zero_s;
    logic                   upper_zero_s;
    logic [3:0]             cur_nib_s;
    logic                   cur_dp_s;
    logic                   cur_blank_s;
    logic [6:0]             cur_pat_s;

    // Digit k is a leading zero when it and every more significant nibble are zero
    always_comb begin
        lead_zero_s  = '0;
        upper_zero_s = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero_s   = upper_zero_s & (shadow_bcd_q[4*k +: 4] == 4'd0);
            lead_zero_s[k] = upper_zero_s;
        end
    end

    // Select the shadow nibble, decimal point and blanking flag of the digit about to be lit
    always_comb begin
        cur_nib_s   = 4'd0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == IW'(k)) begin
                cur_nib_s   = shadow_bcd_q[4*k +: 4];
                cur_dp_s    = shadow_dp_q[k];
                cur_blank_s = (LEAD_BLANK != 0) && (k != 0) && lead_zero_s[k];
            end else begin
                cur_nib_s   = cur_nib_s;
            end
        end
    end

    seg_decoder u_decoder (
        .bcd     (cur_nib_s),
        .pattern (cur_pat_s)
    );

    // Scan FSM, phase timer, digit index and frame buffer handshake
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        shadow_bcd_d  = shadow_bcd_q;
        shadow_dp_d   = shadow_dp_q;
        pend_bcd_d    = pend_bcd_q;
        pend_dp_d     = pend_dp_q;
        pend_v_d      = pend_v_q;
        frame_start_d = 1'b0;
        boundary_s    = 1'b0;
        xfer_s        = upd_valid && upd_ready_q;

        case (state_q)
            ST_IDLE: begin
                idx_d   = {IW{1'b0}};
                timer_d = {TW{1'b0}};
                if (en) begin
                    state_d    = ST_BLANK;
                    boundary_s = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_BLANK: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    idx_d   = {IW{1'b0}};
                    timer_d = {TW{1'b0}};
                end else if (timer_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    timer_d = {TW{1'b0}};
                end else begin
                    timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            ST_SHOW: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    idx_d   = {IW{1'b0}};
                    timer_d = {TW{1'b0}};
                end else if (timer_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    timer_d = {TW{1'b0}};
                    if (idx_q == IDX_LAST) begin
                        idx_d      = {IW{1'b0}};
                        boundary_s = 1'b1;
                    end else begin
                        idx_d      = idx_q + {{(IW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {IW{1'b0}};
                timer_d = {TW{1'b0}};
            end
        endcase

        // Promote the pending frame: at a frame boundary (pulsed) or while idle (silent)
        if (boundary_s && pend_v_q) begin
            shadow_bcd_d  = pend_bcd_q;
            shadow_dp_d   = pend_dp_q;
            pend_v_d      = 1'b0;
            frame_start_d = 1'b1;
        end else if ((state_q == ST_IDLE) && (state_d == ST_IDLE) && pend_v_q) begin
            shadow_bcd_d  = pend_bcd_q;
            shadow_dp_d   = pend_dp_q;
            pend_v_d      = 1'b0;
        end else begin
            frame_start_d = 1'b0;
        end

        // A new transfer lands after any promotion, so a promotion always uses the old frame
        if (xfer_s) begin
            pend_bcd_d = upd_bcd;
            pend_dp_d  = upd_dp;
            pend_v_d   = 1'b1;
        end else begin
            pend_v_d   = pend_v_d;
        end

        // Ready drops right after a transfer and returns one cycle after the buffer empties
        upd_ready_d = !(pend_v_q || xfer_s);
    end

    // Registered digit select and segment bus, both derived from the next state
    always_comb begin
        digit_sel_d = '0;
        seg_d       = 8'h00;
        if (state_d == ST_SHOW) begin
            for (int k = 0; k < DIGITS; k++) begin
                digit_sel_d[k] = (idx_d == IW'(k));
            end
            seg_d[SEG_BIT_DP]  = cur_dp_s;
            seg_d[6:0]         = cur_blank_s ? SEG_OFF : cur_pat_s;
        end else begin
            digit_sel_d = '0;
            seg_d       = 8'h00;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= ST_IDLE;
            idx_q         <= {IW{1'b0}};
            timer_q       <= {TW{1'b0}};
            shadow_bcd_q  <= '0;
            shadow_dp_q   <= '0;
            pend_bcd_q    <= '0;
            pend_dp_q     <= '0;
            pend_v_q      <= 1'b0;
            upd_ready_q   <= 1'b1;
            digit_sel_q   <= '0;
            seg_q         <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            shadow_bcd_q  <= shadow_bcd_d;
            shadow_dp_q   <= shadow_dp_d;
            pend_bcd_q    <= pend_bcd_d;
            pend_dp_q     <= pend_dp_d;
            pend_v_q      <= pend_v_d;
            upd_ready_q   <= upd_ready_d;
            digit_sel_q   <= digit_sel_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign upd_ready   = upd_ready_q;
    assign digit_sel   = digit_sel_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=2, DIV_CNT=4, BLANK_CYC=2.
// A frame is 12 cycles: 2 blank, 4 digit 0, 2 blank, 4 digit 1.
module tb_seg_scan_ctrl;

    localparam int DIGITS    = 2;
    localparam int DIV_CNT   = 4;
    localparam int BLANK_CYC = 2;

    logic       clk = 1'b0;
    logic       res;
    logic       en;
    logic       upd_valid;
    logic       upd_ready;
    logic [7:0] upd_bcd;
    logic [1:0] upd_dp;
    logic [1:0] digit_sel;
    logic [7:0] seg;
    logic       frame_start;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS     (DIGITS),
        .DIV_CNT    (DIV_CNT),
        .BLANK_CYC  (BLANK_CYC),
        .LEAD_BLANK (1)
    ) dut (
        .clk         (clk),
        .res         (res),
        .en          (en),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_bcd     (upd_bcd),
        .upd_dp      (upd_dp),
        .digit_sel   (digit_sel),
        .seg         (seg),
        .frame_start (frame_start)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic adv_to(input int target);
        while (cyc < target) adv();
    endtask

    // Reference segment table {g..a}
    function automatic logic [6:0] pat(input int n);
        case (n)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected {digit_sel,seg} at phase p of a frame
    function automatic logic [9:0] exp_out(input int p, input logic [7:0] s0, input logic [7:0] s1);
        if (p >= 2 && p < 6) return {2'b01, s0};
        else if (p >= 8) return {2'b10, s1};
        else return 10'd0;
    endfunction

    initial begin
        int       base;
        int       p;
        int       pend_val;
        int       shown;
        bit       have_pend;
        bit       have_shown;
        logic [7:0] v;

        res       = 1'b1;
        en        = 1'b1;
        upd_valid = 1'b0;
        upd_bcd   = 8'h00;
        upd_dp    = 2'b00;

        // 1: reset held with en=1
        for (int r = 0; r < 3; r++) begin
            adv();
            check_val("reset_outputs", {digit_sel, seg, upd_ready, frame_start}, {2'b00, 8'h00, 1'b1, 1'b0});
        end

        // 2: load 42 while idle, then scan
        res       = 1'b0;
        en        = 1'b0;
        upd_valid = 1'b1;
        upd_bcd   = 8'h42;
        adv();
        check_val("idle_ready_drop", upd_ready, 1'b0);
        upd_valid = 1'b0;
        adv();
        adv();
        check_val("idle_ready_back", upd_ready, 1'b1);
        en = 1'b1;
        adv();
        cyc = 0;
        for (int i = 0; i < 24; i++) begin
            adv_to(i);
            check_val("scan_42", {digit_sel, seg}, exp_out(i % 12, 8'h5B, 8'h66));
            if (i % 12 == 0) check_val("scan_no_fs", frame_start, 1'b0);
        end

        // 3: tear-free update offered mid digit 0
        adv_to(27);
        upd_valid = 1'b1;
        upd_bcd   = 8'h17;
        adv();
        check_val("upd_ready_fall", upd_ready, 1'b0);
        check_val("d0_still_old", {digit_sel, seg}, {2'b01, 8'h5B});
        upd_valid = 1'b0;
        adv_to(32);
        check_val("d1_still_old", {digit_sel, seg}, {2'b10, 8'h66});
        adv_to(35);
        check_val("ready_low_pend", upd_ready, 1'b0);
        adv_to(36);
        check_val("frame_start_17", frame_start, 1'b1);
        check_val("ready_low_at_fs", upd_ready, 1'b0);
        adv();
        check_val("ready_rise", upd_ready, 1'b1);
        check_val("fs_one_cycle", frame_start, 1'b0);
        adv_to(38);
        check_val("new_d0_7", {digit_sel, seg}, {2'b01, 8'h07});
        adv_to(44);
        check_val("new_d1_1", {digit_sel, seg}, {2'b10, 8'h06});

        // 4: leading blank with dp, invalid nibble
        adv_to(45);
        upd_valid = 1'b1;
        upd_bcd   = 8'h05;
        upd_dp    = 2'b10;
        adv();
        check_val("t4_ready_drop", upd_ready, 1'b0);
        upd_valid = 1'b0;
        adv_to(48);
        check_val("t4_fs", frame_start, 1'b1);
        adv_to(50);
        check_val("d0_5", {digit_sel, seg}, {2'b01, 8'h6D});
        adv_to(56);
        check_val("d1_lead_dp", {digit_sel, seg}, {2'b10, 8'h80});
        adv_to(57);
        upd_valid = 1'b1;
        upd_bcd   = 8'h0C;
        upd_dp    = 2'b00;
        adv();
        upd_valid = 1'b0;
        adv_to(60);
        check_val("t4b_fs", frame_start, 1'b1);
        adv_to(62);
        check_val("d0_dash", {digit_sel, seg}, {2'b01, 8'h40});
        adv_to(68);
        check_val("d1_lead_blank", {digit_sel, seg}, {2'b10, 8'h00});

        // 5: en drop during digit 1, restart, reset with a pending frame
        adv_to(69);
        en = 1'b0;
        adv();
        check_val("en0_dark", {digit_sel, seg}, 10'd0);
        adv();
        check_val("en0_dark2", {digit_sel, seg, frame_start}, 11'd0);
        en = 1'b1;
        adv();
        check_val("restart_blank0", {digit_sel, seg}, 10'd0);
        adv_to(73);
        check_val("restart_blank1", {digit_sel, seg}, 10'd0);
        adv_to(74);
        check_val("restart_d0", {digit_sel, seg}, {2'b01, 8'h40});
        upd_valid = 1'b1;
        upd_bcd   = 8'h99;
        adv();
        check_val("t5_pend_ready", upd_ready, 1'b0);
        upd_valid = 1'b0;
        res       = 1'b1;
        adv();
        check_val("res_mid_frame", {digit_sel, seg, upd_ready, frame_start}, {2'b00, 8'h00, 1'b1, 1'b0});
        res = 1'b0;
        adv();
        base = cyc;
        check_val("res_no_fs", frame_start, 1'b0);
        adv_to(base + 2);
        check_val("res_d0_zero", {digit_sel, seg}, {2'b01, 8'h3F});
        adv_to(base + 8);
        check_val("res_d1_blank", {digit_sel, seg}, {2'b10, 8'h00});
        adv_to(base + 12);
        check_val("pend_lost_no_fs", frame_start, 1'b0);
        check_val("pend_lost_ready", upd_ready, 1'b1);

        // 6: back-to-back offers, a new value every cycle
        have_pend  = 1'b0;
        have_shown = 1'b0;
        pend_val   = 0;
        shown      = 0;
        adv_to(base + 13);
        for (int k = 13; k < 49; k++) begin
            adv_to(base + k);
            p = k % 12;
            if (p == 0) begin
                check_val("b2b_fs", frame_start, have_pend);
                if (have_pend) begin
                    shown      = pend_val;
                    have_shown = 1'b1;
                    have_pend  = 1'b0;
                end
            end
            check_val("b2b_ready", upd_ready, (p == 1));
            if (have_shown && p == 2) begin
                check_val("b2b_d0", {digit_sel, seg}, {2'b01, 1'b0, pat(shown % 10)});
            end
            if (have_shown && p == 8) begin
                check_val("b2b_d1", {digit_sel, seg},
                          {2'b10, 1'b0, ((shown / 10) % 10 == 0) ? 7'h00 : pat((shown / 10) % 10)});
            end
            v[3:0]    = 4'((k % 10));
            v[7:4]    = 4'(((k / 10) % 10));
            upd_bcd   = v;
            upd_valid = 1'b1;
            if (p == 1) begin
                pend_val  = k;
                have_pend = 1'b1;
            end
        end
        upd_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
